// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit: tracks in-flight destinations in a shift-register
// scoreboard, forwards the youngest ready result and stalls decode on load-use.
module hazard_scoreboard #(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STAGES         = 3,
  parameter int LOAD_STAGE     = 2,
  parameter int CNT_WIDTH      = 16,
  localparam int SEL_W         = $clog2(STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic [WIDTH-1:0]          rf_data1,
  input  logic [WIDTH-1:0]          rf_data2,
  input  logic [STAGES*WIDTH-1:0]   stage_data,
  input  logic                      flush,
  output logic [WIDTH-1:0]          operand1,
  output logic [WIDTH-1:0]          operand2,
  output logic [SEL_W-1:0]          fwd_sel1,
  output logic [SEL_W-1:0]          fwd_sel2,
  output logic                      stall,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      fwd_count,
  output logic [SEL_W-1:0]          inflight
);

  localparam int RAW = REG_ADDR_WIDTH;

  logic [STAGES-1:0]     r_valid;
  logic [STAGES*RAW-1:0] r_rd;
  logic [STAGES-1:0]     r_load;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_fwd_cnt;
  logic [SEL_W-1:0]      r_inflight;

  logic [STAGES-1:0]     w_nxt_valid;
  logic [STAGES*RAW-1:0] w_nxt_rd;
  logic [STAGES-1:0]     w_nxt_load;
  logic [SEL_W+1:0]      w_src1;
  logic [SEL_W+1:0]      w_src2;
  logic                  w_hit1, w_hit2, w_rdy1, w_rdy2;
  logic [SEL_W-1:0]      w_k1, w_k2;
  logic                  w_stall;
  logic                  w_fwd_any;

  // Returns {hit, ready, entry}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [SEL_W+1:0] find_src(
    input logic                  used,
    input logic [RAW-1:0]        idx,
    input logic [STAGES-1:0]     vld,
    input logic [STAGES*RAW-1:0] rds,
    input logic [STAGES-1:0]     lds
  );
    logic             hit;
    logic             rdy;
    logic [SEL_W-1:0] k_sel;
    hit   = 1'b0;
    rdy   = 1'b1;
    k_sel = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (used && (idx != '0) && vld[k-1] && (rds[(k-1)*RAW +: RAW] == idx)) begin
        hit   = 1'b1;
        k_sel = SEL_W'(k);
        rdy   = ~lds[k-1] || (k >= LOAD_STAGE);
      end
    end
    return {hit, rdy, k_sel};
  endfunction

  function automatic logic [SEL_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [SEL_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt = cnt + SEL_W'(v[i]);
    end
    return cnt;
  endfunction

  assign w_src1 = find_src(id_rs1_used, id_rs1, r_valid, r_rd, r_load);
  assign w_src2 = find_src(id_rs2_used, id_rs2, r_valid, r_rd, r_load);
  assign w_hit1 = w_src1[SEL_W+1];
  assign w_rdy1 = w_src1[SEL_W];
  assign w_k1   = w_src1[SEL_W-1:0];
  assign w_hit2 = w_src2[SEL_W+1];
  assign w_rdy2 = w_src2[SEL_W];
  assign w_k2   = w_src2[SEL_W-1:0];

  assign w_stall   = id_valid & ((w_hit1 & ~w_rdy1) | (w_hit2 & ~w_rdy2));
  assign fwd_sel1  = w_hit1 ? w_k1 : '0;
  assign fwd_sel2  = w_hit2 ? w_k2 : '0;
  assign w_fwd_any = id_valid & ~w_stall & ((fwd_sel1 != '0) | (fwd_sel2 != '0));

  // Operand select: register file unless an entry is matched.
  always_comb begin
    operand1 = rf_data1;
    operand2 = rf_data2;
    for (int k = 1; k <= STAGES; k++) begin
      if (fwd_sel1 == SEL_W'(k)) operand1 = stage_data[(k-1)*WIDTH +: WIDTH];
      if (fwd_sel2 == SEL_W'(k)) operand2 = stage_data[(k-1)*WIDTH +: WIDTH];
    end
  end

  // Next scoreboard contents: flush wins, otherwise shift and insert decode or a bubble.
  always_comb begin
    w_nxt_valid = '0;
    w_nxt_rd    = '0;
    w_nxt_load  = '0;
    if (!flush) begin
      w_nxt_valid[0]     = id_valid & ~w_stall & id_wr_en & (id_rd != '0);
      w_nxt_rd[RAW-1:0]  = id_rd;
      w_nxt_load[0]      = id_is_load;
      for (int k = 1; k < STAGES; k++) begin
        w_nxt_valid[k]           = r_valid[k-1];
        w_nxt_rd[k*RAW +: RAW]   = r_rd[(k-1)*RAW +: RAW];
        w_nxt_load[k]            = r_load[k-1];
      end
    end else begin
      w_nxt_valid = '0;
    end
  end

  // Scoreboard state, occupancy and saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= '0;
      r_rd        <= '0;
      r_load      <= '0;
      r_inflight  <= '0;
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      r_valid    <= w_nxt_valid;
      r_rd       <= w_nxt_rd;
      r_load     <= w_nxt_load;
      r_inflight <= popcount(w_nxt_valid);
      if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_fwd_any && (r_fwd_cnt != {CNT_WIDTH{1'b1}})) begin
        r_fwd_cnt <= r_fwd_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall       = w_stall;
  assign stall_count = r_stall_cnt;
  assign fwd_count   = r_fwd_cnt;
  assign inflight    = r_inflight;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the pipelined core. It sits between decode and the decode/execute register. It tracks the destination of every in-flight instruction in a shift-register scoreboard STAGES entries deep. It selects forwarded operands over register-file read data and stalls decode on load-use hazards. It also keeps saturating stall and forward performance counters.

Parameters:
WIDTH, 32, datapath/operand width
REG_ADDR_WIDTH, 5, register index width
STAGES, 3, in-flight stages tracked after decode (entry 1 = execute ... entry STAGES = writeback)
LOAD_STAGE, 2, first entry index at which load data is valid (1 <= LOAD_STAGE <= STAGES)
CNT_WIDTH, 16, performance counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid  input  1  decode holds a valid instruction
id_rs1  input  REG_ADDR_WIDTH  source 1 index
id_rs2  input  REG_ADDR_WIDTH  source 2 index
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rd  input  REG_ADDR_WIDTH  destination index
id_wr_en  input  1  instruction writes rd
id_is_load  input  1  result comes from memory
rf_data1  input  WIDTH  register-file read data for rs1
rf_data2  input  WIDTH  register-file read data for rs2
stage_data  input  STAGES*WIDTH  result bus of entry k at bits [k*WIDTH-1:(k-1)*WIDTH]
flush  input  1  kill all in-flight entries
operand1  output  WIDTH  resolved source 1 value
operand2  output  WIDTH  resolved source 2 value
fwd_sel1  output  $clog2(STAGES+1)  0 = register file, k = entry k
fwd_sel2  output  $clog2(STAGES+1)  as fwd_sel1 for source 2
stall  output  1  hold PC and fetch/decode registers; bubble issued
stall_count  output  CNT_WIDTH  saturating count of stall cycles
fwd_count  output  CNT_WIDTH  saturating count of cycles with any forward
inflight  output  $clog2(STAGES+1)  number of valid writing entries

Behaviour:
- Scoreboard entries 1..STAGES each hold {valid, rd, is_load}. An entry is written only when id_wr_en=1 and id_rd!=0.
- On every rising clk, entry k moves to entry k+1 and entry STAGES retires.
- Entry 1 loads from decode when id_valid & ~stall. Otherwise entry 1 loads a bubble (valid=0).
- flush=1 clears all entries at the clock edge; the flush has priority over the shift and the decode insert. Counters are not affected by flush.
- Source match: source s is used, index != 0, and entry k is valid with rd == index. The youngest match (lowest k) wins. Writes to x0 never match.
- Data ready for matched entry k: ~is_load OR k >= LOAD_STAGE.
- Youngest match ready: fwd_sel = k, operand = stage_data slice k.
- No match: fwd_sel = 0, operand = rf_data.
- stall = id_valid & (some used source's youngest match is not ready). stall is combinational, same cycle as decode.
- While stall=1: operands and fwd_sel still drive their resolved/unresolved values, but downstream ignores them since a bubble is inserted. Decode re-presents the same instruction on the next cycle.
- A stall lasts exactly LOAD_STAGE-k cycles for a load matched at entry k.
- stall_count increments by 1 on each clk where stall=1 and holds at all-ones.
- fwd_count increments on each clk where id_valid & ~stall and either fwd_sel != 0; it also saturates at all-ones.
- inflight = population count of valid entries, registered with the scoreboard.
- Reset (asynchronous, immediate):
  - all entries invalid, both counters 0, inflight 0.
  - Consequently stall=0, fwd_sel1/2=0, operand1/2 = rf_data1/2.
  - Reset mid-stall abandons the stall immediately.
- flush and stall in the same cycle: the entries clear, so on the next cycle stall re-evaluates to 0.
- id_valid=0: stall=0, and a bubble enters entry 1.

Test Plan:
- Reset with id_valid=1, rs1=5 used, rf_data1=0xAAAA0000 -> stall=0, fwd_sel1=0, operand1=0xAAAA0000, both counters 0, inflight 0.
- ALU op rd=3, then next-cycle op with rs1=3, stage_data entry1=0x00000011 -> fwd_sel1=1, operand1=0x11, stall=0, fwd_count=1 after the edge.
- Load rd=7 (LOAD_STAGE=2) followed by a use of rs2=7 -> stall=1 for exactly 1 cycle, bubble inserted. The next cycle gives fwd_sel2=2, operand2=stage_data entry2, stall_count=1.
- Write-after-write: rd=4 written in entries 1 and 2 with different data, consumer rs1=4 -> fwd_sel1=1 (youngest), operand1 = entry1 data.
- Instruction with rd=0 and id_wr_en=1, consumer rs1=0 -> no match, fwd_sel1=0, inflight unchanged.
- During a load-use stall, assert flush -> next cycle stall=0, inflight=0. Assert reset mid-stream -> all outputs return to reset values asynchronously. Drive 2^CNT_WIDTH+5 stall cycles -> stall_count holds at 0xFFFF.
